// File: rtl/hpu_pkg.sv
// Shared types and constants for the HPU video memory arbiter.
// Holds the arbiter state/owner enums and VRAM bus widths.
package hpu_pkg;

  typedef enum logic [0:0] {
    S_ACTIVE,
    S_BLANK
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HPU,
    OWN_HOST
  } arb_owner_t;

  localparam int VRAM_AW  = 16;
  localparam int VRAM_DW  = 8;
  localparam int RASTER_W = 10;

endpackage

// File: rtl/hpu_vram_arbiter_if.sv
// VRAM arbiter bus: raster position, HPU and host request ports, memory port.
// slave = arbiter side, master = requesters plus external memory side.
interface hpu_vram_arbiter_if;
  import hpu_pkg::*;

  logic [RASTER_W-1:0] true_line;
  logic [RASTER_W-1:0] true_column;

  logic               hpu_req;
  logic [VRAM_AW-1:0] hpu_addr;
  logic               hpu_gnt;
  logic               hpu_rvalid;
  logic [VRAM_DW-1:0] hpu_rdata;

  logic               host_req;
  logic               host_we;
  logic [VRAM_AW-1:0] host_addr;
  logic [VRAM_DW-1:0] host_wdata;
  logic               host_gnt;
  logic               host_rvalid;
  logic [VRAM_DW-1:0] host_rdata;

  logic [VRAM_AW-1:0] mem_addr;
  logic [VRAM_DW-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_en;
  logic [VRAM_DW-1:0] mem_rdata;

  modport slave (
    input  true_line,
    input  true_column,
    input  hpu_req,
    input  hpu_addr,
    output hpu_gnt,
    output hpu_rvalid,
    output hpu_rdata,
    input  host_req,
    input  host_we,
    input  host_addr,
    input  host_wdata,
    output host_gnt,
    output host_rvalid,
    output host_rdata,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_en,
    input  mem_rdata
  );

  modport master (
    output true_line,
    output true_column,
    output hpu_req,
    output hpu_addr,
    input  hpu_gnt,
    input  hpu_rvalid,
    input  hpu_rdata,
    output host_req,
    output host_we,
    output host_addr,
    output host_wdata,
    input  host_gnt,
    input  host_rvalid,
    input  host_rdata,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_en,
    output mem_rdata
  );

endinterface

// File: rtl/hpu_vram_rsp_pipe.sv
// Two-stage owner tag pipeline steering mem_rdata to HPU or host.
// Ports: clk, reset (async, low), own (grant tag), mem_rdata in; rvalid/rdata out.
module hpu_vram_rsp_pipe
  import hpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  arb_owner_t         own,
  input  logic [VRAM_DW-1:0] mem_rdata,
  output logic               hpu_rvalid,
  output logic [VRAM_DW-1:0] hpu_rdata,
  output logic               host_rvalid,
  output logic [VRAM_DW-1:0] host_rdata
);

  arb_owner_t own_q1;
  arb_owner_t own_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q1 <= OWN_NONE;
      own_q2 <= OWN_NONE;
    end else begin
      own_q1 <= own;
      own_q2 <= own_q1;
    end
  end

  assign hpu_rvalid  = (own_q2 == OWN_HPU);
  assign host_rvalid = (own_q2 == OWN_HOST);

  // Data is forced to zero outside its valid cycle so idle
  // outputs never leak another requester's read data.
  assign hpu_rdata  = hpu_rvalid  ? mem_rdata : '0;
  assign host_rdata = host_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/hpu_vram_arbiter.sv
// Video memory arbiter: HPU owns active display, host owns blanking.
// Ports: clk, reset (async, low), bus (slave). Option: HPU_VRAM_HOST_FAIRNESS_EN.
module hpu_vram_arbiter
  import hpu_pkg::*;
#(
  parameter int ACTIVE_W = 512,
  parameter int ACTIVE_H = 480,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  hpu_vram_arbiter_if.slave   bus
);

  localparam int WAIT_W =
    ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  logic       blank;
  arb_state_t state;
  arb_state_t state_nxt;
  logic       host_boost;
  logic       hpu_gnt;
  logic       host_gnt;
  arb_owner_t own;

  logic [VRAM_AW-1:0] mem_addr;
  logic [VRAM_DW-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_en;

  assign blank =
    (bus.true_column >= RASTER_W'(ACTIVE_W)) ||
    (bus.true_line   >= RASTER_W'(ACTIVE_H));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACTIVE: if (blank)  state_nxt = S_BLANK;
      S_BLANK:  if (!blank) state_nxt = S_ACTIVE;
      default:  state_nxt = S_ACTIVE;
    endcase
  end

`ifdef HPU_VRAM_HOST_FAIRNESS_EN
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Counts host losses in active display; saturates at the
  // limit so the host keeps its boost until it is served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == S_BLANK || host_gnt) begin
      wait_cnt <= '0;
    end else if (bus.host_req && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign host_boost = (wait_cnt >= WAIT_MAX);
`else
  logic [WAIT_W-1:0] unused_max_wait;

  assign unused_max_wait = WAIT_W'(MAX_WAIT);
  assign host_boost      = 1'b0;
`endif

  // Grants are suppressed while reset is held so every
  // output reads zero during reset.
  always_comb begin
    hpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (reset) begin
      unique case (1'b1)
        bus.hpu_req && bus.host_req: begin
          if (state == S_BLANK || host_boost) begin
            host_gnt = 1'b1;
          end else begin
            hpu_gnt = 1'b1;
          end
        end
        bus.hpu_req && !bus.host_req: hpu_gnt  = 1'b1;
        !bus.hpu_req && bus.host_req: host_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    own = OWN_NONE;
    if (hpu_gnt) begin
      own = OWN_HPU;
    end else if (host_gnt && !bus.host_we) begin
      own = OWN_HOST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= hpu_gnt || host_gnt;
      if (hpu_gnt) begin
        mem_we    <= 1'b0;
        mem_addr  <= bus.hpu_addr;
        mem_wdata <= '0;
      end else if (host_gnt) begin
        mem_we    <= bus.host_we;
        mem_addr  <= bus.host_addr;
        mem_wdata <= bus.host_wdata;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end
    end
  end

  assign bus.hpu_gnt   = hpu_gnt;
  assign bus.host_gnt  = host_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  hpu_vram_rsp_pipe u_rsp (
    .clk         (clk),
    .reset       (reset),
    .own         (own),
    .mem_rdata   (bus.mem_rdata),
    .hpu_rvalid  (bus.hpu_rvalid),
    .hpu_rdata   (bus.hpu_rdata),
    .host_rvalid (bus.host_rvalid),
    .host_rdata  (bus.host_rdata)
  );

endmodule

// File: doc/hpu_vram_arbiter.md
Name: hpu_vram_arbiter

Overview:
- Shares the single 16-bit-address / 8-bit-data video memory port between two requesters: the HPU tile/pixel fetch engine and a host (CPU/DMA) access port.
- The HPU wins during active display. The host wins during blanking.
- Sits between `hpu` and the external memory interface in the top level; takes raster position from the `vga` counters.
- Fully pipelined: one memory access per clock, fixed read latency.

Parameters:
- ACTIVE_W, 512, visible width in true columns; x >= ACTIVE_W is horizontal blank.
- ACTIVE_H, 480, visible height in true lines; y >= ACTIVE_H is vertical blank.
- MAX_WAIT, 15, host starvation limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- true_line  input  10  current raster line from vga
- true_column  input  10  current raster column from vga
- hpu_req  input  1  HPU read request
- hpu_addr  input  16  HPU read address
- hpu_gnt  output  1  HPU request accepted this cycle
- hpu_rvalid  output  1  hpu_rdata valid
- hpu_rdata  output  8  HPU read data
- host_req  input  1  host request
- host_we  input  1  1 = write, 0 = read
- host_addr  input  16  host address
- host_wdata  input  8  host write data
- host_gnt  output  1  host request accepted this cycle
- host_rvalid  output  1  host_rdata valid
- host_rdata  output  8  host read data
- mem_addr  output  16  memory address (registered)
- mem_wdata  output  8  memory write data (registered)
- mem_we  output  1  memory write strobe (registered)
- mem_en  output  1  memory access enable (registered)
- mem_rdata  input  8  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset state: all outputs 0; state = S_ACTIVE; wait counter = 0.
- Region decode (combinational): blank = (true_column >= ACTIVE_W) || (true_line >= ACTIVE_H).
- States (registered, evaluated every cycle):
  - S_ACTIVE: HPU has priority. Goes to S_BLANK when blank = 1.
  - S_BLANK: host has priority. Goes to S_ACTIVE when blank = 0.
- Grant rules:
  - gnt is combinational from req and state. A requester holds req/addr/we/wdata stable until it sees gnt.
  - Exactly one grant per cycle at most. If neither requester is asserting req, no grant and mem_en = 0 next cycle.
  - Both requesting: the priority owner of the current state wins; the loser sees gnt = 0 and retries.
  - Single requester: it is granted in either state. The host may use idle active-region cycles.
- Pipeline, with grant in cycle N:
  - N+1: mem_en = 1, mem_addr/mem_we/mem_wdata hold the granted request.
  - N+2: for reads, {requester}_rvalid = 1 and {requester}_rdata = mem_rdata.
  - Host writes produce no rvalid.
- Throughput: back-to-back grants are legal every cycle. An owner tag is pipelined two stages so rvalid is routed correctly when grants alternate.
- Region boundary: the state changes one cycle after blank toggles. Requests in flight complete normally.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced after reset is released for requests granted before reset.
- mem_wdata is don't-care when mem_we = 0 but is driven registered, not X.

Optional Feature:
- Macro HPU_VRAM_HOST_FAIRNESS_EN.
- Enabled:
  - A 4-bit-or-wider wait counter increments each S_ACTIVE cycle in which host_req = 1 and host_gnt = 0.
  - When the counter reaches MAX_WAIT, the host wins the next contended cycle. The counter clears on any host grant and in S_BLANK.
- Disabled: the counter is absent. In S_ACTIVE the host is granted only on cycles without hpu_req.

Decomposition:
- Package hpu_pkg holds:
  - typedef enum logic [0:0] {S_ACTIVE, S_BLANK} arb_state_t;
  - typedef enum logic [1:0] {OWN_NONE, OWN_HPU, OWN_HOST} arb_owner_t;
  - localparams VRAM_AW = 16 and VRAM_DW = 8.
- Sub-module hpu_vram_rsp_pipe: the two-stage owner/valid shift register that routes mem_rdata to the correct rvalid/rdata. The arbiter core holds the FSM and grant logic.

Test Plan:
- HPU-only reads in active region: hpu_req with addrs 0x1000, 0x1001, 0x1002 on consecutive cycles -> hpu_gnt = 1 each cycle; hpu_rvalid on cycles +2, +3, +4 carrying the model data in order.
- Contention at column 100, line 50: both requesting -> hpu_gnt = 1 and host_gnt = 0 every cycle. Without the feature the host starves. With the feature, host_gnt = 1 on cycle MAX_WAIT+1 = 16.
- Contention at column 600 (blank): both requesting -> host_gnt = 1 and hpu_gnt = 0. A host write of 0xA5 to 0x2000 gives mem_we = 1, mem_addr = 0x2000, mem_wdata = 0xA5 one cycle later, with no host_rvalid.
- Alternating grants across the column 511 -> 512 boundary: rdata routes to the correct requester and no response is lost or duplicated.
- Reset asserted low one cycle after a host read grant: all outputs 0 immediately. After release, no host_rvalid appears, and the state is S_ACTIVE.
- Idle active cycle: host read of 0x3FFF with hpu_req = 0 -> host_gnt = 1 and host_rvalid two cycles later.
